sprite_motion_controller: RTL and testbench

Per-frame sequencer that owns the ship and bullet sprite positions consumed by the pixel index selector. It samples player buttons, advances ship and bullet positions once per video frame on the start of vertical sync, and presents atomically updated 19-bit top-left coordinates (640x480 space) to the index selector. It enforces screen-boundary clamping, single-bullet launch and bullet retirement.

---
 rtl/sprite_pkg.sv | 25 ++
 rtl/sat_step.sv | 35 +++
 rtl/sprite_motion_controller.sv | 167 ++++++++++++++++
 tb/tb_sprite_motion_controller.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite geometry, off-screen park coordinate and sequencer state encoding.
// The pixel index selector uses the same dimension constants.
package sprite_pkg;

    localparam int COORD_W      = 19;
    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int SHIP_W       = 100;
    localparam int SHIP_H       = 100;
    localparam int BULLET_W     = 20;
    localparam int BULLET_H     = 20;
    localparam int SHIP_SPEED   = 4;
    localparam int BULLET_SPEED = 8;
    localparam int PARK_XY      = 700;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIP   = 2'd1,
        BULLET = 2'd2,
        COMMIT = 2'd3
    } state_t;

endpackage

// File: rtl/sat_step.sv
// Saturating single-axis step: moves pos by step toward lo (dec) or hi (inc), clamped to [lo, hi].
// Combinational, zero latency; no flow control. Both or neither direction holds pos.
module sat_step
    import sprite_pkg::*;
(
    input  coord_t pos,
    input  coord_t step,
    input  coord_t lo,
    input  coord_t hi,
    input  logic   dec,
    input  logic   inc,
    output coord_t nxt
);

    always_comb begin
        nxt = pos;
        if (dec && !inc) begin
            // Compare before subtracting so an unsigned wrap can never appear.
            if (pos <= lo)
                nxt = lo;
            else if ((pos - lo) >= step)
                nxt = pos - step;
            else
                nxt = lo;
        end else if (inc && !dec) begin
            if (pos >= hi)
                nxt = hi;
            else if ((hi - pos) >= step)
                nxt = pos + step;
            else
                nxt = hi;
        end
    end

endmodule

// File: rtl/sprite_motion_controller.sv
// Per-frame ship/bullet position sequencer: IDLE -> SHIP -> BULLET -> COMMIT on each vsync fall.
// Latency: outputs update 4 cycles after the frame tick; ticks arriving while busy are dropped.
module sprite_motion_controller
    import sprite_pkg::*;
#(
    parameter int SCREEN_W     = sprite_pkg::SCREEN_W,
    parameter int SCREEN_H     = sprite_pkg::SCREEN_H,
    parameter int SHIP_W       = sprite_pkg::SHIP_W,
    parameter int SHIP_H       = sprite_pkg::SHIP_H,
    parameter int BULLET_W     = sprite_pkg::BULLET_W,
    parameter int BULLET_H     = sprite_pkg::BULLET_H,
    parameter int SHIP_SPEED   = sprite_pkg::SHIP_SPEED,
    parameter int BULLET_SPEED = sprite_pkg::BULLET_SPEED,
    parameter int PARK_XY      = sprite_pkg::PARK_XY
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         vsync,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_fire,
    output logic [18:0]  min_x,
    output logic [18:0]  min_y,
    output logic [18:0]  min_x_bullet,
    output logic [18:0]  min_y_bullet,
    output logic         bullet_active,
    output logic         busy
);

    localparam coord_t X_MAX      = coord_t'(SCREEN_W - SHIP_W);
    localparam coord_t Y_MAX      = coord_t'(SCREEN_H - SHIP_H);
    localparam coord_t SHIP_X0    = coord_t'((SCREEN_W - SHIP_W) / 2);
    localparam coord_t SHIP_Y0    = coord_t'(SCREEN_H - SHIP_H);
    localparam coord_t SHIP_STEP  = coord_t'(SHIP_SPEED);
    localparam coord_t BUL_STEP   = coord_t'(BULLET_SPEED);
    localparam coord_t BUL_H      = coord_t'(BULLET_H);
    localparam coord_t NOSE_OFFS  = coord_t'((SHIP_W - BULLET_W) / 2);
    localparam coord_t PARK       = coord_t'(PARK_XY);

    state_t state, state_nxt;
    logic   vsync_q, fire_q, fire_pending;
    logic   frame_tick, fire_edge;
    logic   ld_ship, ld_bullet, do_commit;

    coord_t ship_x_w, ship_y_w, bul_x_w, bul_y_w;
    logic   bul_act_w;
    coord_t ship_x_nxt, ship_y_nxt, bul_x_nxt, bul_y_nxt;
    logic   bul_act_nxt, spawn;

    assign frame_tick = vsync_q && !vsync;
    assign fire_edge  = btn_fire && !fire_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_tick) state_nxt = SHIP;
            SHIP:    state_nxt = BULLET;
            BULLET:  state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ld_ship   = (state == SHIP);
        ld_bullet = (state == BULLET);
        do_commit = (state == COMMIT);
    end

    sat_step u_step_x (
        .pos (min_x),
        .step(SHIP_STEP),
        .lo  ('0),
        .hi  (X_MAX),
        .dec (btn_left),
        .inc (btn_right),
        .nxt (ship_x_nxt)
    );

    sat_step u_step_y (
        .pos (min_y),
        .step(SHIP_STEP),
        .lo  ('0),
        .hi  (Y_MAX),
        .dec (btn_up),
        .inc (btn_down),
        .nxt (ship_y_nxt)
    );

    // Bullet works from the committed position and the freshly computed ship position.
    always_comb begin
        bul_x_nxt   = min_x_bullet;
        bul_y_nxt   = min_y_bullet;
        bul_act_nxt = bullet_active;
        spawn       = 1'b0;
        if (bullet_active) begin
            if (min_y_bullet < BUL_STEP) begin
                bul_act_nxt = 1'b0;
                bul_x_nxt   = PARK;
                bul_y_nxt   = PARK;
            end else begin
                bul_y_nxt = min_y_bullet - BUL_STEP;
            end
        end else if (fire_pending) begin
            spawn       = 1'b1;
            bul_act_nxt = 1'b1;
            bul_x_nxt   = ship_x_w + NOSE_OFFS;
            bul_y_nxt   = (ship_y_w >= BUL_H) ? (ship_y_w - BUL_H) : '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vsync_q       <= 1'b1;
            fire_q        <= 1'b0;
            fire_pending  <= 1'b0;
            busy          <= 1'b0;
            ship_x_w      <= SHIP_X0;
            ship_y_w      <= SHIP_Y0;
            bul_x_w       <= PARK;
            bul_y_w       <= PARK;
            bul_act_w     <= 1'b0;
            min_x         <= SHIP_X0;
            min_y         <= SHIP_Y0;
            min_x_bullet  <= PARK;
            min_y_bullet  <= PARK;
            bullet_active <= 1'b0;
        end else begin
            vsync_q <= vsync;
            fire_q  <= btn_fire;
            busy    <= (state_nxt != IDLE);

            // A new edge in the spawn cycle survives the clear and fires next frame.
            if (ld_bullet && spawn)
                fire_pending <= 1'b0;
            if (fire_edge && !bullet_active)
                fire_pending <= 1'b1;

            if (ld_ship) begin
                ship_x_w <= ship_x_nxt;
                ship_y_w <= ship_y_nxt;
            end
            if (ld_bullet) begin
                bul_x_w   <= bul_x_nxt;
                bul_y_w   <= bul_y_nxt;
                bul_act_w <= bul_act_nxt;
            end
            if (do_commit) begin
                min_x         <= ship_x_w;
                min_y         <= ship_y_w;
                min_x_bullet  <= bul_x_w;
                min_y_bullet  <= bul_y_w;
                bullet_active <= bul_act_w;
            end
        end
    end

endmodule

// File: tb/tb_sprite_motion_controller.sv
// Bench for sprite_motion_controller: per-frame reference model feeds a scoreboard queue,
// entries are popped and compared when busy falls at the end of each update sequence.
module tb_sprite_motion_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        vsync;
    logic        btn_left, btn_right, btn_up, btn_down, btn_fire;
    logic [18:0] min_x, min_y, min_x_bullet, min_y_bullet;
    logic        bullet_active, busy;

    typedef struct {
        int x;
        int y;
        int bx;
        int by;
        int act;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mx, my, mbx, mby, mact, mpend;

    sprite_motion_controller dut (
        .clock        (clock),
        .reset        (reset),
        .vsync        (vsync),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_fire     (btn_fire),
        .min_x        (min_x),
        .min_y        (min_y),
        .min_x_bullet (min_x_bullet),
        .min_y_bullet (min_y_bullet),
        .bullet_active(bullet_active),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        mx = 270; my = 380; mbx = 700; mby = 700; mact = 0; mpend = 0;
    endtask

    task automatic fire_pulse();
        @(negedge clock) btn_fire = 1'b1;
        @(negedge clock) btn_fire = 1'b0;
        if (mact == 0) mpend = 1;
    endtask

    task automatic check_outputs(input string tag, input exp_t e);
        check_val({tag, ".x"},   int'(min_x),         e.x);
        check_val({tag, ".y"},   int'(min_y),         e.y);
        check_val({tag, ".bx"},  int'(min_x_bullet),  e.bx);
        check_val({tag, ".by"},  int'(min_y_bullet),  e.by);
        check_val({tag, ".act"}, int'(bullet_active), e.act);
    endtask

    task automatic run_frame(input string tag, input bit l, input bit r, input bit u, input bit d);
        exp_t e;
        int   cyc;
        if (r && !l)      mx = (mx + 4 > 540) ? 540 : mx + 4;
        else if (l && !r) mx = (mx >= 4) ? mx - 4 : 0;
        if (d && !u)      my = (my + 4 > 380) ? 380 : my + 4;
        else if (u && !d) my = (my >= 4) ? my - 4 : 0;
        if (mact != 0) begin
            if (mby < 8) begin
                mact = 0; mbx = 700; mby = 700;
            end else begin
                mby = mby - 8;
            end
        end else if (mpend != 0) begin
            mbx = mx + 40;
            mby = (my >= 20) ? my - 20 : 0;
            mact = 1; mpend = 0;
        end
        e = '{x: mx, y: my, bx: mbx, by: mby, act: mact};
        sb_q.push_back(e);

        @(negedge clock);
        btn_left = l; btn_right = r; btn_up = u; btn_down = d;
        vsync = 1'b0;
        cyc = 99;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            if (!busy) begin
                cyc = c;
                break;
            end
        end
        check_val({tag, ".lat"}, cyc, 4);
        e = sb_q.pop_front();
        check_outputs(tag, e);
        vsync = 1'b1;
        btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0;
        @(negedge clock);
    endtask

    initial begin
        exp_t rst_e;
        reset = 1'b1; vsync = 1'b1;
        btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; btn_fire = 0;
        model_reset();
        rst_e = '{x: 270, y: 380, bx: 700, by: 700, act: 0};
        repeat (3) @(negedge clock);
        check_outputs("rst", rst_e);
        check_val("rst.busy", int'(busy), 0);
        reset = 1'b0;
        @(negedge clock);

        run_frame("idle", 0, 0, 0, 0);

        fire_pulse();
        run_frame("spawn", 0, 0, 0, 0);
        for (int i = 0; i < 46; i++) begin
            if (i == 10) fire_pulse();
            run_frame("fly", 0, 0, 0, 0);
        end
        check_val("retired.act", int'(bullet_active), 0);

        for (int i = 0; i < 5; i++) run_frame("move", 1, 0, 1, 0);
        fire_pulse();
        run_frame("respawn", 0, 0, 0, 0);
        for (int i = 0; i < 60 && mact != 0; i++) run_frame("fly2", 0, 0, 0, 0);

        for (int i = 0; i < 140; i++) run_frame("right", 0, 1, 0, 0);
        run_frame("both", 1, 1, 0, 0);
        for (int i = 0; i < 100; i++) run_frame("up", 0, 0, 1, 0);

        fire_pulse();
        run_frame("top_spawn", 0, 0, 0, 0);
        run_frame("top_retire", 0, 0, 0, 0);

        // Mid-sequence reset with a fire pending.
        fire_pulse();
        @(negedge clock) vsync = 1'b0;
        repeat (2) @(negedge clock);
        check_val("mid.busy_before", int'(busy), 1);
        reset = 1'b1;
        vsync = 1'b1;
        #1;
        model_reset();
        check_outputs("mid_rst", rst_e);
        check_val("mid_rst.busy", int'(busy), 0);
        @(negedge clock) reset = 1'b0;
        @(negedge clock);
        run_frame("post_rst", 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
